// File: rtl/sel_packer_pkg.sv
// Shared types and constants for the beat-serial field packer.
// Holds the FSM state encoding and the beat-counter sizing.
package sel_packer_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  localparam int          BEAT_W   = 4;
  localparam logic [3:0]  BEAT_MAX = 4'd15;

endpackage

// File: rtl/sel_insert.sv
// Masked insert of an unsigned slice into an accumulator at a bit offset.
// Ports: acc_i/field_i/offset_i in; acc_o (updated word), clip_o (slice overran word) out.
module sel_insert #(
  parameter int WORD_W  = 8,
  parameter int FIELD_W = 4,
  parameter int OFF_W   = 3
) (
  input  logic [WORD_W-1:0]  acc_i,
  input  logic [FIELD_W-1:0] field_i,
  input  logic [OFF_W-1:0]   offset_i,
  output logic [WORD_W-1:0]  acc_o,
  output logic               clip_o
);

  logic [OFF_W-1:0] idx;

  always_comb begin
    acc_o = acc_i;
    idx   = '0;
    for (int i = 0; i < FIELD_W; i++) begin
      idx = offset_i + OFF_W'(i);
      // bits past the top of the word are dropped
      if (int'(offset_i) + i < WORD_W)
        acc_o[idx] = field_i[i];
    end
  end

  // flagged on position alone, whatever the dropped bits hold
  assign clip_o = (int'(offset_i) + FIELD_W) > WORD_W;

endmodule

// File: rtl/sel_packer.sv
// Beat-serial field packer: builds a word from offset slices, emits it
// sign- and zero-extended. Ports: in_* beat stream, out_* word stream.
module sel_packer
  import sel_packer_pkg::*;
#(
  parameter int WORD_W  = 8,
  parameter int FIELD_W = 4,
  parameter int OUT_W   = 32,
  localparam int OFF_W  = $clog2(WORD_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FIELD_W-1:0] in_field,
  input  logic [OFF_W-1:0]   in_offset,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_sword,
  output logic [OUT_W-1:0]   out_zword,
  output logic               out_clip,
  output logic [BEAT_W-1:0]  out_beats
);

  state_e              state_q;
  logic [WORD_W-1:0]   acc_q, acc_d;
  logic                clip_q, clip_d, ins_clip;
  logic [BEAT_W-1:0]   beats_q, beats_d;
  logic                vld_q;
  logic [OUT_W-1:0]    sword_q, zword_q;
  logic [OUT_W-1:0]    sword_d, zword_d;
  logic                oclip_q;
  logic [BEAT_W-1:0]   obeats_q;
  logic                accept, drain;

  sel_insert #(
    .WORD_W  (WORD_W),
    .FIELD_W (FIELD_W),
    .OFF_W   (OFF_W)
  ) u_ins (
    .acc_i    (acc_q),
    .field_i  (in_field),
    .offset_i (in_offset),
    .acc_o    (acc_d),
    .clip_o   (ins_clip)
  );

  assign in_ready = (state_q == COLLECT) || out_ready;
  assign accept   = in_valid && in_ready;
  assign drain    = vld_q && out_ready;

  always_comb begin
    clip_d  = clip_q | ins_clip;
    beats_d = (beats_q == BEAT_MAX) ? beats_q : beats_q + 1'b1;
    // sign comes from the whole word, never from the slice
    sword_d = OUT_W'($signed(acc_d));
    zword_d = OUT_W'(acc_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= COLLECT;
      acc_q    <= '0;
      clip_q   <= 1'b0;
      beats_q  <= '0;
      vld_q    <= 1'b0;
      sword_q  <= '0;
      zword_q  <= '0;
      oclip_q  <= 1'b0;
      obeats_q <= '0;
    end else if (accept && in_last) begin
      state_q  <= HOLD;
      vld_q    <= 1'b1;
      sword_q  <= sword_d;
      zword_q  <= zword_d;
      oclip_q  <= clip_d;
      obeats_q <= beats_d;
      acc_q    <= '0;
      clip_q   <= 1'b0;
      beats_q  <= '0;
    end else if (accept) begin
      // also covers a non-last beat taken while HOLD drains
      state_q  <= COLLECT;
      vld_q    <= vld_q && !out_ready;
      acc_q    <= acc_d;
      clip_q   <= clip_d;
      beats_q  <= beats_d;
    end else if (drain) begin
      state_q  <= COLLECT;
      vld_q    <= 1'b0;
    end
  end

  assign out_valid = vld_q;
  assign out_sword = sword_q;
  assign out_zword = zword_q;
  assign out_clip  = oclip_q;
  assign out_beats = obeats_q;

endmodule

// File: tb/tb_sel_packer.sv
// Directed bench for sel_packer: vector table plus
// backpressure, async reset and saturation sequences.
module tb_sel_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_field;
  logic [2:0]  in_offset;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sword;
  logic [31:0] out_zword;
  logic        out_clip;
  logic [3:0]  out_beats;

  int n_chk = 0;
  int n_fail = 0;

  sel_packer #(
    .WORD_W  (8),
    .FIELD_W (4),
    .OUT_W   (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_field  (in_field),
    .in_offset (in_offset),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sword (out_sword),
    .out_zword (out_zword),
    .out_clip  (out_clip),
    .out_beats (out_beats)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  f;
    logic [2:0]  off;
    logic        last;
    logic [31:0] s;
    logic [31:0] z;
    logic        clip;
    logic [3:0]  beats;
  } vec_t;

  vec_t tab[8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [3:0] f, input logic [2:0] off,
                      input logic last);
    in_valid  = 1'b1;
    in_field  = f;
    in_offset = off;
    in_last   = last;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] s,
                         input logic [31:0] z, input logic c,
                         input logic [3:0] b);
    chk({tag, " valid"}, 32'(out_valid), 32'd1);
    chk({tag, " sword"}, out_sword, s);
    chk({tag, " zword"}, out_zword, z);
    chk({tag, " clip"},  32'(out_clip), 32'(c));
    chk({tag, " beats"}, 32'(out_beats), 32'(b));
  endtask

  initial begin
    // f, off, last, sword, zword, clip, beats
    tab[0] = '{4'hA, 3'd4, 1'b0, 32'h0, 32'h0, 1'b0, 4'd0};
    tab[1] = '{4'h5, 3'd0, 1'b1, 32'hFFFFFFA5, 32'h000000A5, 1'b0, 4'd2};
    tab[2] = '{4'h7, 3'd6, 1'b1, 32'hFFFFFFC0, 32'h000000C0, 1'b1, 4'd1};
    tab[3] = '{4'hF, 3'd0, 1'b0, 32'h0, 32'h0, 1'b0, 4'd0};
    tab[4] = '{4'h0, 3'd2, 1'b1, 32'h00000003, 32'h00000003, 1'b0, 4'd2};
    tab[5] = '{4'h1, 3'd7, 1'b1, 32'hFFFFFF80, 32'h00000080, 1'b1, 4'd1};
    tab[6] = '{4'h3, 3'd5, 1'b0, 32'h0, 32'h0, 1'b0, 4'd0};
    tab[7] = '{4'h3, 3'd4, 1'b1, 32'h00000030, 32'h00000030, 1'b1, 4'd2};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_field  = '0;
    in_offset = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #12;
    chk("reset valid", 32'(out_valid), 32'd0);
    chk("reset sword", out_sword, 32'd0);
    chk("reset zword", out_zword, 32'd0);
    chk("reset clip",  32'(out_clip), 32'd0);
    chk("reset beats", 32'(out_beats), 32'd0);
    rst_n = 1'b1;
    step();
    chk("reset in_ready", 32'(in_ready), 32'd1);

    // back-to-back beats, out_ready held high
    for (int i = 0; i < 8; i++) begin
      beat(tab[i].f, tab[i].off, tab[i].last);
      chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd1);
      step();
      if (tab[i].last)
        chk_out($sformatf("vec%0d", i), tab[i].s, tab[i].z,
                tab[i].clip, tab[i].beats);
    end

    // backpressure: word 0x30 held while a last beat waits
    out_ready = 1'b0;
    beat(4'h1, 3'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp%0d in_ready", i), 32'(in_ready), 32'd0);
      step();
      chk_out($sformatf("bp%0d", i), 32'h30, 32'h30, 1'b1, 4'd2);
    end
    out_ready = 1'b1;
    #1;
    chk("bp release in_ready", 32'(in_ready), 32'd1);
    step();
    chk_out("bp reload", 32'h1, 32'h1, 1'b0, 4'd1);

    // partial word then asynchronous reset between edges
    beat(4'hF, 3'd4, 1'b0);
    step();
    chk("mid valid drop", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async valid", 32'(out_valid), 32'd0);
    chk("async zword", out_zword, 32'd0);
    chk("async beats", 32'(out_beats), 32'd0);
    #1;
    rst_n = 1'b1;
    beat(4'h2, 3'd0, 1'b1);
    step();
    chk_out("post reset", 32'h2, 32'h2, 1'b0, 4'd1);

    // beat counter saturates at 15
    for (int i = 0; i < 20; i++) begin
      beat(4'h0, 3'd0, i == 19);
      step();
    end
    chk_out("saturate", 32'h0, 32'h0, 1'b0, 4'd15);

    // consumer drains, nothing new offered
    in_valid = 1'b0;
    step();
    chk("drain valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sel_packer.md
# sel_packer

Beat-serial field packer: writes unsigned FIELD_W slices into a WORD_W accumulator at arbitrary bit offsets (indexed part-select `+:` writes), then emits the completed word with two interpretations. The signed output is sign-extended from the full accumulator, never from an individual slice. It is the write side of the select-signedness rules: slices are always unsigned, and the sign is applied only to the whole word. It sits between a field-decode stream and any consumer that needs a sign- or zero-extended operand.

## Interface
Parameters:
- WORD_W, 8, accumulator width (≥ 2)
- FIELD_W, 4, width of one inserted slice (1..WORD_W)
- OUT_W, 32, output width (≥ WORD_W)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  beat offered
- in_ready  out  1  beat can be accepted
- in_field  in  FIELD_W  unsigned slice data
- in_offset  in  $clog2(WORD_W)  LSB position of slice in accumulator
- in_last  in  1  final beat of the current word
- out_valid  out  1  packed word available
- out_ready  in  1  consumer takes word
- out_sword  out  OUT_W  $signed(acc) sign-extended to OUT_W
- out_zword  out  OUT_W  acc zero-extended to OUT_W
- out_clip  out  1  some beat of this word had in_offset+FIELD_W > WORD_W
- out_beats  out  4  beats in this word, saturating at 15

## Operation
- States are COLLECT and HOLD. Reset enters COLLECT with acc=0, clip=0, beats=0, out_valid=0, and all outputs 0.
- A beat is accepted when in_valid && in_ready. Then acc[in_offset +: FIELD_W] is loaded with in_field:
  - Bits that would land at index ≥ WORD_W are dropped; in-range bits are written.
  - Bits outside the slice are unchanged. Later beats overwrite earlier beats bit-for-bit.
- clip is set for the word if any accepted beat has in_offset+FIELD_W > WORD_W. It is set even when the dropped bits are zero.
- beats increments on each accepted beat and saturates at 15.
- When a beat with in_last=1 is accepted:
  - The output registers load from the post-insert acc, clip and beats.
  - out_valid goes to 1 and the state goes to HOLD.
  - acc, clip and beats clear to 0 for the next word.
- In HOLD, outputs are held stable until out_valid && out_ready.
- in_ready = (state==COLLECT) || out_ready. A last beat accepted in the same cycle that HOLD drains reloads the output registers, so out_valid stays 1. A non-last beat accepted in that cycle returns the block to COLLECT.
- A word of one beat (in_last on the first beat) is legal.
- Sign rule: out_sword uses acc[WORD_W-1] as the sign bit. in_field is never sign-extended.

## Timing
- Output latency is 1 cycle: out_valid rises on the clock edge that accepts the last beat.
- Sustained throughput is 1 beat/cycle when out_ready=1.
- in_ready depends combinationally on out_ready. No other input-to-output combinational paths exist.
- Reset is asynchronous at any point, including mid-word or in HOLD. It clears all state immediately, and any partial word is discarded.

## Structure
- sel_packer_pkg holds:
  - the state enum typedef (COLLECT, HOLD);
  - the beat-counter width constant 4 and saturation value 15.
- Sub-module sel_insert is a pure combinational masked insert. Inputs: acc, field, offset. Outputs: new acc and a clip bit. It is instantiated once.

## Test plan
(WORD_W=8, FIELD_W=4, OUT_W=32)
- Two-beat word: (4'hA, off 4), then (4'h5, off 0, last) → out_sword=32'hFFFFFFA5, out_zword=32'h000000A5, out_clip=0, out_beats=2.
- Clipped write: single beat (4'h7, off 6, last) → acc=8'hC0, out_sword=32'hFFFFFFC0, out_zword=32'h000000C0, out_clip=1, out_beats=1.
- Overlap: (4'hF, off 0), then (4'h0, off 2, last) → out_sword=out_zword=32'h00000003.
- Backpressure:
  - Stimulus: after a word completes, out_ready=0 for 3 cycles with in_valid=1.
  - Required: in_ready=0 and outputs stable for those cycles.
  - Then out_ready=1 with a last beat (4'h1, off 0) offered in the same cycle → next cycle out_valid=1 and out_zword=32'h00000001.
- Reset mid-word:
  - Stimulus: accept (4'hF, off 4), then pulse rst_n low between clock edges.
  - Required: out_valid=0 immediately.
  - Then a beat (4'h2, off 0, last) → out_sword=32'h00000002 and out_beats=1, with no residue from the earlier beat.
- Beat counter saturation: 20 beats of (4'h0, off 0) with the last flagged → out_beats=15, out_sword=0.
